// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash responder over an internal byte array
// Optional fast read (0x0B + 8 dummy clocks) is enabled by defining SPI_FLASH_FAST_READ_EN.
module spi_flash_responder #(
   parameter int MEM_BYTES   = 4096,
   parameter int ADDR_W      = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              busy,
   output logic              wel,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_wdata,
   output logic [7:0]        bd_rdata
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_RD     = 3'd3;
   localparam logic [2:0] S_PG     = 3'd4;
   localparam logic [2:0] S_STAT   = 3'd5;
   localparam logic [2:0] S_IGN    = 3'd6;
`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [2:0] S_DUMMY  = 3'd7;
   logic                  is_fast;
`endif

   logic [7:0]             mem [MEM_BYTES];
   logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
   logic                   cs_s, sck_s, mosi_s, cs_d, sck_d;
   logic                   cs_rise, cs_fall, sck_rise, sck_fall;
   logic [2:0]             state, bit_cnt, tx_cnt;
   logic [1:0]             addr_cnt;
   logic [6:0]             rx_sr;
   logic [7:0]             rx_next, tx_sr, rd_q;
   logic [23:0]            addr;
   logic                   is_prog, pg_wrote, rd_pend, rd_load;
   logic                   byte_done, spi_we;

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign sck_rise  = sck_s & ~sck_d;
   assign sck_fall  = ~sck_s & sck_d;
   assign busy      = ~cs_s;
   assign rx_next   = {rx_sr, mosi_s};
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign spi_we    = ~cs_s && ~cs_d && (state == S_PG) && byte_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync   <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_d      <= 1'b1;
         sck_d     <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_d      <= cs_s;
         sck_d     <= sck_s;
      end
   end

   // Single write port; an SPI program write pre-empts a same-cycle backdoor write.
   always_ff @(posedge clk) begin
      if (spi_we)
         mem[addr[ADDR_W-1:0]] <= rx_next;
      else if (bd_we)
         mem[bd_addr] <= bd_wdata;
      rd_q <= mem[addr[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bd_rdata <= 8'h00;
      else      bd_rdata <= mem[bd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         bit_cnt  <= 3'd0;
         tx_cnt   <= 3'd0;
         addr_cnt <= 2'd0;
         rx_sr    <= 7'd0;
         tx_sr    <= 8'd0;
         addr     <= 24'd0;
         is_prog  <= 1'b0;
         pg_wrote <= 1'b0;
         rd_pend  <= 1'b0;
         rd_load  <= 1'b0;
         spi_miso <= 1'b0;
         wel      <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
         is_fast  <= 1'b0;
`endif
      end else begin
         // Array read issued via rd_pend lands in tx_sr two clocks later.
         rd_pend <= 1'b0;
         rd_load <= rd_pend;
         if (rd_load) tx_sr <= rd_q;
         if (cs_rise) begin
            if (state == S_PG && pg_wrote) wel <= 1'b0;
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            tx_cnt   <= 3'd0;
            pg_wrote <= 1'b0;
            spi_miso <= 1'b0;
         end else if (cs_fall) begin
            state    <= S_CMD;
            bit_cnt  <= 3'd0;
            tx_cnt   <= 3'd0;
            addr_cnt <= 2'd0;
            rx_sr    <= 7'd0;
         end else if (~cs_s && state != S_IDLE) begin
            if (sck_rise) begin
               rx_sr   <= rx_next[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (byte_done) begin
                  case (state)
                     S_CMD: begin
                        case (rx_next)
                           8'h03: begin
                              state   <= S_ADDR;
                              is_prog <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
                              is_fast <= 1'b0;
`endif
                           end
`ifdef SPI_FLASH_FAST_READ_EN
                           8'h0B: begin
                              state   <= S_ADDR;
                              is_prog <= 1'b0;
                              is_fast <= 1'b1;
                           end
`endif
                           8'h02: begin
                              state   <= wel ? S_ADDR : S_IGN;
                              is_prog <= 1'b1;
                           end
                           8'h06: begin wel <= 1'b1; state <= S_IGN; end
                           8'h04: begin wel <= 1'b0; state <= S_IGN; end
                           8'h05: begin
                              state <= S_STAT;
                              tx_sr <= {6'b0, wel, 1'b0};
                           end
                           default: state <= S_IGN;
                        endcase
                     end
                     S_ADDR: begin
                        addr     <= {addr[15:0], rx_next};
                        addr_cnt <= addr_cnt + 2'd1;
                        if (addr_cnt == 2'd2) begin
                           if (is_prog) state <= S_PG;
`ifdef SPI_FLASH_FAST_READ_EN
                           else if (is_fast) state <= S_DUMMY;
`endif
                           else begin
                              state   <= S_RD;
                              rd_pend <= 1'b1;
                           end
                        end
                     end
`ifdef SPI_FLASH_FAST_READ_EN
                     S_DUMMY: begin
                        state   <= S_RD;
                        rd_pend <= 1'b1;
                     end
`endif
                     S_PG: begin
                        addr[7:0] <= addr[7:0] + 8'd1;
                        pg_wrote  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            if (sck_fall && (state == S_RD || state == S_STAT)) begin
               spi_miso <= tx_sr[7];
               tx_sr    <= {tx_sr[6:0], 1'b0};
               tx_cnt   <= tx_cnt + 3'd1;
               if (tx_cnt == 3'd7) begin
                  if (state == S_RD) begin
                     addr    <= addr + 24'd1;
                     rd_pend <= 1'b1;
                  end else begin
                     tx_sr <= {6'b0, wel, 1'b0};
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - bench for spi_flash_responder (command table plus scoreboard of read bytes)
module tb_spi_flash_responder;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_cs_n, spi_sck, spi_mosi;
   logic        spi_miso, busy, wel;
   logic        bd_we;
   logic [11:0] bd_addr;
   logic [7:0]  bd_wdata, bd_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] sb_q[$];

   typedef struct {
      string       name;
      logic [7:0]  op;
      bit          has_addr;
      logic [23:0] addr;
      int          nd;
      logic [7:0]  d0;
      logic [7:0]  d1;
      bit          rd;
      logic [7:0]  e0;
      logic [7:0]  e1;
      logic        exp_wel;
   } vec_t;

   vec_t vecs[8];

   spi_flash_responder #(.MEM_BYTES(4096), .ADDR_W(12), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .busy(busy), .wel(wel),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_wdata = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic bd_check(input string nm, input logic [11:0] a, input logic [7:0] exp);
      @(negedge clk);
      bd_addr = a;
      @(negedge clk);
      chk(nm, {24'd0, bd_rdata}, {24'd0, exp});
   endtask

   task automatic spi_bits(input logic [7:0] o, input int n, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi = o[i];
         repeat (HALF) @(negedge clk);
         r[i] = spi_miso;
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (HALF + 4) @(negedge clk);
   endtask

   task automatic run_cmd(input string name, input logic [7:0] op, input bit has_addr,
                          input logic [23:0] addr, input int ndummy, input int nd,
                          input logic [7:0] d0, input logic [7:0] d1, input bit rd,
                          input logic [7:0] e0, input logic [7:0] e1, input logic exp_wel);
      logic [7:0] r, e;
      if (rd) begin
         sb_q.push_back(e0);
         if (nd > 1) sb_q.push_back(e1);
      end
      cs_low();
      spi_bits(op, 8, r);
      if (has_addr) begin
         spi_bits(addr[23:16], 8, r);
         spi_bits(addr[15:8], 8, r);
         spi_bits(addr[7:0], 8, r);
      end
      for (int k = 0; k < ndummy; k++) spi_bits(8'h00, 8, r);
      for (int k = 0; k < nd; k++) begin
         spi_bits((k == 0) ? d0 : d1, 8, r);
         if (rd) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL %s: read byte %0d has no expected entry", name, k);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("%s_byte%0d", name, k), {24'd0, r}, {24'd0, e});
            end
         end
      end
      cs_high();
      chk($sformatf("%s_wel", name), {31'd0, wel}, {31'd0, exp_wel});
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: run exceeded cycle budget");
      $fatal(1);
   end

   initial begin
      logic [7:0] r;
      vecs[0] = '{"read_12bit_wrap", 8'h03, 1'b1, 24'h002001, 2, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h3C, 1'b0};
      vecs[1] = '{"prog_no_wren",    8'h02, 1'b1, 24'h000010, 1, 8'h77, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[2] = '{"rdsr_idle",       8'h05, 1'b0, 24'h000000, 2, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[3] = '{"wren",            8'h06, 1'b0, 24'h000000, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
      vecs[4] = '{"rdsr_wel",        8'h05, 1'b0, 24'h000000, 2, 8'h00, 8'h00, 1'b1, 8'h02, 8'h02, 1'b1};
      vecs[5] = '{"prog_page_wrap",  8'h02, 1'b1, 24'h0000FF, 2, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[6] = '{"rdsr_after_prog", 8'h05, 1'b0, 24'h000000, 1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[7] = '{"read_0ff",        8'h03, 1'b1, 24'h0000FF, 1, 8'h00, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0};

      rst = 1'b0; spi_cs_n = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0;
      bd_we = 1'b0; bd_addr = 12'd0; bd_wdata = 8'd0;
      repeat (4) @(negedge clk);
      chk("reset_miso", {31'd0, spi_miso}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_wel",  {31'd0, wel}, 32'd0);
      chk("reset_bd_rdata", {24'd0, bd_rdata}, 32'd0);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("busy_cs_low", {31'd0, busy}, 32'd1);
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("busy_cs_high", {31'd0, busy}, 32'd0);

      bd_write(12'h001, 8'hA5);
      bd_write(12'h002, 8'h3C);
      bd_write(12'h010, 8'h55);
      bd_write(12'h040, 8'h9D);

      for (int i = 0; i < 8; i++)
         run_cmd(vecs[i].name, vecs[i].op, vecs[i].has_addr, vecs[i].addr, 0, vecs[i].nd,
                 vecs[i].d0, vecs[i].d1, vecs[i].rd, vecs[i].e0, vecs[i].e1, vecs[i].exp_wel);

      bd_check("bd_prog_no_wren", 12'h010, 8'h55);
      bd_check("bd_page_ff", 12'h0FF, 8'h11);
      bd_check("bd_page_wrap", 12'h000, 8'h22);
      run_cmd("read_000", 8'h03, 1'b1, 24'h000000, 0, 1, 8'h00, 8'h00, 1'b1, 8'h22, 8'h00, 1'b0);

      // Abort a program mid-byte: nothing written, wel survives, next read is normal.
      run_cmd("wren2", 8'h06, 1'b0, 24'h0, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      cs_low();
      chk("busy_in_cmd", {31'd0, busy}, 32'd1);
      spi_bits(8'h02, 8, r);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h00, 8, r);
      spi_bits(8'h40, 8, r);
      spi_bits(8'hAA, 5, r);
      cs_high();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_wel_kept", {31'd0, wel}, 32'd1);
      bd_check("bd_abort_040", 12'h040, 8'h9D);
      run_cmd("read_after_abort", 8'h03, 1'b1, 24'h000040, 0, 1, 8'h00, 8'h00, 1'b1, 8'h9D, 8'h00, 1'b1);
      run_cmd("wrdi", 8'h04, 1'b0, 24'h0, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      bd_write(12'hFFF, 8'h81);
      bd_write(12'h000, 8'h7E);
      run_cmd("read_wrap_fff", 8'h03, 1'b1, 24'h000FFF, 0, 2, 8'h00, 8'h00, 1'b1, 8'h81, 8'h7E, 1'b0);
`ifdef SPI_FLASH_FAST_READ_EN
      run_cmd("fast_read_fff", 8'h0B, 1'b1, 24'h000FFF, 1, 2, 8'h00, 8'h00, 1'b1, 8'h81, 8'h7E, 1'b0);
`else
      run_cmd("fast_read_off", 8'h0B, 1'b1, 24'h000FFF, 1, 2, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
`endif

      if (sb_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
